piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 103 ++++++++++
 tb/tb_piso_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out transmitter with framing flags.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
`timescale 1ns/1ps
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             SER_OUT,
    output logic             SER_OUTn,
    output logic             SER_VALID,
    output logic             SER_FIRST,
    output logic             DONE
);
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
`else
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
`ifdef PISO_PARITY_EN
    logic             parity_bit;
`endif

    logic             first_bit;
    logic             head_bit;
    logic [WIDTH-1:0] data_adv;
    logic [WIDTH-1:0] shift_adv;

    // The register always holds the bits not yet presented, oldest at the output end.
    assign first_bit = (MSB_FIRST != 0) ? DATA_IN[WIDTH-1]   : DATA_IN[0];
    assign head_bit  = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
    assign data_adv  = (MSB_FIRST != 0) ? (DATA_IN << 1)     : (DATA_IN >> 1);
    assign shift_adv = (MSB_FIRST != 0) ? (shift_reg << 1)   : (shift_reg >> 1);

    assign LOAD_READY = (state == IDLE);
    assign SER_OUTn   = ~SER_OUT;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            SER_OUT    <= 1'b0;
            SER_VALID  <= 1'b0;
            SER_FIRST  <= 1'b0;
            DONE       <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    DONE      <= 1'b0;
                    SER_OUT   <= 1'b0;
                    SER_VALID <= 1'b0;
                    SER_FIRST <= 1'b0;
                    if (LOAD_VALID) begin
                        state      <= SHIFT;
                        shift_reg  <= data_adv;
                        bit_cnt    <= '0;
                        SER_OUT    <= first_bit;
                        SER_VALID  <= 1'b1;
                        SER_FIRST  <= 1'b1;
`ifdef PISO_PARITY_EN
                        parity_bit <= ^DATA_IN;
`endif
                    end
                end
                SHIFT: begin
                    SER_FIRST <= 1'b0;
                    if (bit_cnt == LAST_IDX) begin
                        state     <= IDLE;
                        SER_OUT   <= 1'b0;
                        SER_VALID <= 1'b0;
                        DONE      <= 1'b1;
                    end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        shift_reg <= shift_adv;
                        SER_OUT   <= head_bit;
`ifdef PISO_PARITY_EN
                        if (bit_cnt == DATA_LAST) begin
                            SER_OUT <= parity_bit;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for an MSB-first and an LSB-first serializer instance.
`timescale 1ns/1ps
module tb_piso_serializer;
    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int SPACING = WIDTH + 2;
    localparam bit PAR_EN  = 1'b1;
`else
    localparam int SPACING = WIDTH + 1;
    localparam bit PAR_EN  = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lv_m, lv_l;
    logic [WIDTH-1:0] data_m, data_l;
    logic             rdy_m, rdy_l;
    logic             so_m, son_m, sv_m, sf_m, dn_m;
    logic             so_l, son_l, sv_l, sf_l, dn_l;

    exp_t q_m[$];
    exp_t q_l[$];
    logic prev_last [2];
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
        .CLK(clk), .RSTn(rst_n), .LOAD_VALID(lv_m), .LOAD_READY(rdy_m), .DATA_IN(data_m),
        .SER_OUT(so_m), .SER_OUTn(son_m), .SER_VALID(sv_m), .SER_FIRST(sf_m), .DONE(dn_m)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
        .CLK(clk), .RSTn(rst_n), .LOAD_VALID(lv_l), .LOAD_READY(rdy_l), .DATA_IN(data_l),
        .SER_OUT(so_l), .SER_OUTn(son_l), .SER_VALID(sv_l), .SER_FIRST(sf_l), .DONE(dn_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bit(input string name, input int lane, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s lane%0d: got %b, expected %b at t=%0t", name, lane, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_output(input int lane, input logic so, input logic son, input logic sv,
                                input logic sf, input logic dn, input logic rdy);
        exp_t e;
        bit   empty;
        check_bit("ser_outn", lane, son, ~so);
        check_bit("load_ready", lane, rdy, ~sv);
        check_bit("done", lane, dn, prev_last[lane]);
        if (sv === 1'b1) begin
            empty = (lane == 0) ? (q_m.size() == 0) : (q_l.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_bit lane%0d: got ser_valid=1, expected idle", lane);
                prev_last[lane] = 1'b0;
            end else begin
                if (lane == 0) e = q_m.pop_front();
                else           e = q_l.pop_front();
                check_bit("ser_out", lane, so, e.b);
                check_bit("ser_first", lane, sf, e.first);
                prev_last[lane] = e.last;
            end
        end else begin
            check_bit("idle_ser_out", lane, so, 1'b0);
            check_bit("idle_ser_first", lane, sf, 1'b0);
            prev_last[lane] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_output(0, so_m, son_m, sv_m, sf_m, dn_m, rdy_m);
            check_output(1, so_l, son_l, sv_l, sf_l, dn_l, rdy_l);
        end
    end

    // seq lists the expected line bits in transmit order, leftmost first.
    task automatic apply_stimulus(input int lane, input logic [WIDTH-1:0] data,
                                  input logic [WIDTH-1:0] seq, input logic par,
                                  input bit hold, output int acc);
        bit   got;
        exp_t e;
        @(negedge clk);
        if (lane == 0) begin data_m = data; lv_m = 1'b1; end
        else           begin data_l = data; lv_l = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 4 * SPACING; i++) begin
            if (((lane == 0) ? rdy_m : rdy_l) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout lane%0d: got no load_ready, expected accept", lane);
            lv_m = 1'b0;
            lv_l = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        for (int i = 0; i < WIDTH; i++) begin
            e.b     = seq[WIDTH-1-i];
            e.first = (i == 0);
            e.last  = (i == WIDTH - 1) && !PAR_EN;
            if (lane == 0) q_m.push_back(e);
            else           q_l.push_back(e);
        end
        if (PAR_EN) begin
            e.b = par; e.first = 1'b0; e.last = 1'b1;
            if (lane == 0) q_m.push_back(e);
            else           q_l.push_back(e);
        end
        if (!hold) begin
            if (lane == 0) lv_m = 1'b0;
            else           lv_l = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_bit({tag, "_ser_out"}, 0, so_m, 1'b0);
        check_bit({tag, "_ser_outn"}, 0, son_m, 1'b1);
        check_bit({tag, "_ready"}, 0, rdy_m, 1'b1);
        check_bit({tag, "_valid"}, 0, sv_m, 1'b0);
        check_bit({tag, "_first"}, 0, sf_m, 1'b0);
        check_bit({tag, "_done"}, 0, dn_m, 1'b0);
    endtask

    initial begin
        int a0, a1, a2;
        lv_m = 1'b0; lv_l = 1'b0;
        data_m = '0; data_l = '0;
        prev_last[0] = 1'b0;
        prev_last[1] = 1'b0;
        #12;
        check_reset_values("reset");
        check_bit("reset_ser_outn", 1, son_l, 1'b1);
        check_bit("reset_ready", 1, rdy_l, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        $display("[TB] directed words");
        apply_stimulus(0, 8'hA5, 8'b10100101, 1'b0, 1'b0, a0);
        apply_stimulus(1, 8'h01, 8'b10000000, 1'b1, 1'b0, a0);
        apply_stimulus(1, 8'h2D, 8'b10110100, 1'b0, 1'b0, a0);
        apply_stimulus(0, 8'h2D, 8'b00101101, 1'b0, 1'b0, a0);
        apply_stimulus(0, 8'h07, 8'b00000111, 1'b1, 1'b0, a0);

        $display("[TB] back-to-back with load_valid held");
        apply_stimulus(0, 8'h3C, 8'b00111100, 1'b0, 1'b1, a1);
        apply_stimulus(0, 8'hFF, 8'b11111111, 1'b0, 1'b0, a2);
        check_int("accept_spacing", a2 - a1, SPACING);

        $display("[TB] asynchronous reset mid-word");
        apply_stimulus(0, 8'hA5, 8'b10100101, 1'b0, 1'b0, a0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        check_reset_values("abort");
        #0.5;
        rst_n = 1'b1;
        q_m.delete();
        prev_last[0] = 1'b0;
        apply_stimulus(0, 8'h2D, 8'b00101101, 1'b0, 1'b0, a0);

        repeat (SPACING + 4) @(negedge clk);
        check_int("queue_drain", q_m.size() + q_l.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
